data_accumulator_avg: RTL and testbench
=======================================

Name: data_accumulator_avg

Overview:
- Parametrised successor to the single-shot capture accumulator.
- Captures a fixed-length record of signed ADC samples on each dataCaptureStrobe trigger.
- Sums a runtime-selected number of records point-by-point into an on-chip accumulator RAM (coherent averaging) with saturation.
- Presents the summed record word-by-word to a slower readout path through a ready/read handshake.

Parameters:
- DATA_WIDTH, 8: signed input sample width.
- ACC_WIDTH, 16: signed accumulator/output width; must be >= DATA_WIDTH.
- DEPTH, 256: samples per record; power of two, >= 4.
- REC_WIDTH, 8: width of numRecords / recordCount.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- inputData  in  DATA_WIDTH  signed ADC sample, valid every cycle.
- dataCaptureStrobe  in  1  trigger; starts one record capture.
- start  in  1  one-cycle pulse; arms a new averaging run.
- abort  in  1  one-cycle pulse; cancels any run.
- numRecords  in  REC_WIDTH  records to sum; sampled on start.
- dataRead  in  1  pop request for dataOut.
- dataReadyToRead  out  1  dataOut holds a valid result word.
- dataEmpty  out  1  no unread result words.
- dataOut  out  ACC_WIDTH  signed accumulated word.
- busy  out  1  run in progress (not IDLE).
- recordCount  out  REC_WIDTH  records completed in current run.
- overflow  out  1  sticky; any accumulate saturated this run.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; dataOut=0, dataReadyToRead=0, dataEmpty=1, busy=0, recordCount=0, overflow=0.
  - Sample/read address counters = 0.
  - RAM contents are don't-care.
- States: IDLE, WAIT_TRIG, CAPTURE, DRAIN, READOUT.
- IDLE:
  - start=1 latches numRecords; a value of 0 is treated as 1.
  - Clears recordCount and overflow; next state WAIT_TRIG; busy=1 from the next cycle.
- WAIT_TRIG:
  - dataCaptureStrobe=1 in cycle t: inputData at t is sample index 0.
  - State CAPTURE covers indices 1..DEPTH-1 on the following DEPTH-1 consecutive cycles, with no gaps.
- CAPTURE:
  - dataCaptureStrobe is ignored.
  - Per index i:
    - If recordCount==0: acc[i] = sign-extend(inputData).
    - Otherwise: acc[i] = sat(acc[i] + sign-extend(inputData)).
  - Read-modify-write is pipelined; one sample per cycle is sustained with no stalls.
- Saturation:
  - A result above 2^(ACC_WIDTH-1)-1 clamps to that value.
  - A result below -2^(ACC_WIDTH-1) clamps to that value.
  - Either clamp sets overflow, which holds until the next accepted start or reset.
- End of record:
  - The cycle after index DEPTH-1 is written, recordCount increments.
  - If recordCount == latched numRecords, next state is DRAIN.
  - Otherwise next state is WAIT_TRIG; a strobe is accepted from that cycle on.
- DRAIN:
  - Waits for the pipeline to flush, then fetches acc[0].
  - dataOut=acc[0], dataReadyToRead=1 and dataEmpty=0 no later than 4 cycles after the last sample cycle.
  - Next state READOUT.
- READOUT handshake:
  - Pop occurs when dataRead=1 and dataReadyToRead=1 in cycle t.
  - On a pop: dataReadyToRead=0 at t+1; next word on dataOut with dataReadyToRead=1 at t+2.
  - Peak throughput is 1 word per 2 cycles.
  - dataRead while dataReadyToRead=0 is ignored.
  - dataOut holds its value until the next pop.
- After the pop of word DEPTH-1:
  - dataReadyToRead=0, dataEmpty=1, state IDLE, busy=0.
  - dataOut retains the last word.
  - The read address wraps to 0.
- start outside IDLE is ignored.
- abort, from any state:
  - Next cycle: IDLE with all outputs at reset values except overflow and recordCount, which hold for inspection.
  - abort and start in the same cycle: abort wins; no run starts.
- dataCaptureStrobe in IDLE, DRAIN or READOUT is ignored.
- Reset asserted mid-CAPTURE or mid-READOUT takes effect immediately (async); no partial record survives.

Test Plan:
- Reset: assert rst=0 mid-CAPTURE -> same cycle: busy=0, dataReadyToRead=0, dataEmpty=1, dataOut=0, recordCount=0.
- Single record, DEPTH=16, numRecords=1:
  - Stimulus: inputData ramps -3,-4,...,-18 from the strobe cycle.
  - Required: 16 pops yield 16'hFFFD, 16'hFFFC, ..., 16'hFFEE; then dataEmpty=1, busy=0.
- Averaging, numRecords=4, inputData held at -3, four strobes:
  - Required: recordCount=4; every word = -12 (16'hFFF4); overflow=0.
- Saturation, ACC_WIDTH=10, inputData=127, numRecords=8:
  - Required: every word = 511; overflow=1.
  - Repeat with inputData=-128 -> every word = -512.
- Handshake, dataRead held at 1 throughout READOUT:
  - Required: exactly DEPTH pops, one per 2 cycles; extra dataRead after dataEmpty=1 changes nothing.
- Corner cases:
  - Strobe pulsed mid-CAPTURE -> no restart; index count unaffected.
  - start+abort in the same cycle -> remains IDLE.
  - numRecords=0 -> behaves as 1 record.

Source files
------------

// File: rtl/data_accumulator_avg.sv
// Coherent-averaging capture block: sums N triggered records of signed samples
// point-by-point into an accumulator RAM with saturation, then streams the result out.
module data_accumulator_avg #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int DEPTH      = 256,
    parameter int REC_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] inputData,
    input  logic                         dataCaptureStrobe,
    input  logic                         start,
    input  logic                         abort,
    input  logic        [REC_WIDTH-1:0]  numRecords,
    input  logic                         dataRead,
    output logic                         dataReadyToRead,
    output logic                         dataEmpty,
    output logic signed [ACC_WIDTH-1:0]  dataOut,
    output logic                         busy,
    output logic        [REC_WIDTH-1:0]  recordCount,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, WAIT_TRIG, CAPTURE, DRAIN, READOUT} state_t;

    state_t                        state_q, state_d;
    logic         [REC_WIDTH-1:0]  num_q, num_d;
    logic         [REC_WIDTH-1:0]  rec_cnt_q, rec_cnt_d;
    logic                          ovf_q, ovf_d;
    logic         [AW-1:0]         cap_idx_q, cap_idx_d;
    logic         [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                          p_valid_q, p_valid_d;
    logic         [AW-1:0]         p_idx_q;
    logic signed  [ACC_WIDTH-1:0]  p_data_q, p_data_d;
    logic                          p_first_q, p_first_d;
    logic                          fetch_q, fetch_d;
    logic signed  [ACC_WIDTH-1:0]  dout_q, dout_d;
    logic                          ready_q, ready_d;
    logic                          empty_q, empty_d;

    logic signed  [ACC_WIDTH-1:0]  mem [DEPTH];
    logic signed  [ACC_WIDTH-1:0]  rd_data_q;
    logic         [AW-1:0]         rd_addr;
    logic signed  [ACC_WIDTH:0]    sum_w;
    logic signed  [ACC_WIDTH-1:0]  wr_data;
    logic                          sat_hit;

    // Second pipeline stage: RAM word is back, combine it with the registered sample.
    always_comb begin
        sum_w   = (ACC_WIDTH+1)'(rd_data_q) + (ACC_WIDTH+1)'(p_data_q);
        wr_data = p_data_q;
        sat_hit = 1'b0;
        if (!p_first_q) begin
            if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
                sat_hit = 1'b1;
                wr_data = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end else begin
                wr_data = sum_w[ACC_WIDTH-1:0];
            end
        end
    end

    // NOTE: the accumulator RAM has no reset so it maps onto block RAM; the first record of every run overwrites all words.
    always_ff @(posedge clk) begin
        if (p_valid_q) mem[p_idx_q] <= wr_data;
        rd_data_q <= mem[rd_addr];
    end

    // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        rec_cnt_d = rec_cnt_q;
        ovf_d     = ovf_q | (p_valid_q & sat_hit);
        cap_idx_d = cap_idx_q;
        rd_ptr_d  = rd_ptr_q;
        p_valid_d = 1'b0;
        p_data_d  = ACC_WIDTH'(inputData);
        p_first_d = (rec_cnt_q == '0);
        fetch_d   = 1'b0;
        dout_d    = dout_q;
        ready_d   = ready_q;
        empty_d   = empty_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d     = (numRecords == '0) ? REC_WIDTH'(1) : numRecords;
                    rec_cnt_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (dataCaptureStrobe) begin
                    p_valid_d = 1'b1;
                    cap_idx_d = cap_idx_q + 1'b1;
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (cap_idx_q != '0) begin
                    p_valid_d = 1'b1;
                    cap_idx_d = cap_idx_q + 1'b1;
                end else begin
                    // Index counter has wrapped: this cycle writes the last word of the record.
                    rec_cnt_d = rec_cnt_q + 1'b1;
                    state_d   = (rec_cnt_d == num_q) ? DRAIN : WAIT_TRIG;
                end
            end
            DRAIN: begin
                fetch_d = 1'b1;
                state_d = READOUT;
            end
            READOUT: begin
                if (fetch_q) begin
                    dout_d  = rd_data_q;
                    ready_d = 1'b1;
                    empty_d = 1'b0;
                end else if (dataRead && ready_q) begin
                    ready_d = 1'b0;
                    if (rd_ptr_q == LAST_IDX) begin
                        rd_ptr_d = '0;
                        empty_d  = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        fetch_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort beats everything, but keeps recordCount and overflow for inspection.
        if (abort) begin
            state_d   = IDLE;
            num_d     = num_q;
            rec_cnt_d = rec_cnt_q;
            ovf_d     = ovf_q;
            cap_idx_d = '0;
            rd_ptr_d  = '0;
            p_valid_d = 1'b0;
            fetch_d   = 1'b0;
            dout_d    = '0;
            ready_d   = 1'b0;
            empty_d   = 1'b1;
        end

        rd_addr = (state_q == DRAIN || state_q == READOUT) ? rd_ptr_d : cap_idx_q;
    end

    // NOTE: registers update with non-blocking assignments so every one samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            num_q     <= '0;
            rec_cnt_q <= '0;
            ovf_q     <= 1'b0;
            cap_idx_q <= '0;
            rd_ptr_q  <= '0;
            p_valid_q <= 1'b0;
            p_idx_q   <= '0;
            p_data_q  <= '0;
            p_first_q <= 1'b0;
            fetch_q   <= 1'b0;
            dout_q    <= '0;
            ready_q   <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            rec_cnt_q <= rec_cnt_d;
            ovf_q     <= ovf_d;
            cap_idx_q <= cap_idx_d;
            rd_ptr_q  <= rd_ptr_d;
            p_valid_q <= p_valid_d;
            p_idx_q   <= cap_idx_q;
            p_data_q  <= p_data_d;
            p_first_q <= p_first_d;
            fetch_q   <= fetch_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            empty_q   <= empty_d;
        end
    end

    assign dataReadyToRead = ready_q;
    assign dataEmpty       = empty_q;
    assign dataOut         = dout_q;
    assign busy            = (state_q != IDLE);
    assign recordCount     = rec_cnt_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_data_accumulator_avg.sv
// Bench for data_accumulator_avg: two instances (16-bit and 10-bit accumulators) share
// one stimulus stream and are compared against a per-record saturating reference model.
module tb_data_accumulator_avg;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int RW    = 8;
    localparam int AW_A  = 16;
    localparam int AW_B  = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] inputData;
    logic                 dataCaptureStrobe, start, abort, dataRead;
    logic [RW-1:0]        numRecords;

    logic                   rdy_a, emp_a, busy_a, ovf_a;
    logic signed [AW_A-1:0] out_a;
    logic [RW-1:0]          rc_a;
    logic                   rdy_b, emp_b, busy_b, ovf_b;
    logic signed [AW_B-1:0] out_b;
    logic [RW-1:0]          rc_b;

    int checks = 0;
    int errors = 0;

    // Reference model: expected accumulator contents and sticky overflow per width.
    int m_a[DEPTH];
    int m_b[DEPTH];
    bit mo_a, mo_b;
    int recs_done;

    always #5 clk = ~clk;

    data_accumulator_avg #(.DATA_WIDTH(DW), .ACC_WIDTH(AW_A), .DEPTH(DEPTH), .REC_WIDTH(RW)) dut_a (
        .clk(clk), .rst(rst), .inputData(inputData), .dataCaptureStrobe(dataCaptureStrobe),
        .start(start), .abort(abort), .numRecords(numRecords), .dataRead(dataRead),
        .dataReadyToRead(rdy_a), .dataEmpty(emp_a), .dataOut(out_a), .busy(busy_a),
        .recordCount(rc_a), .overflow(ovf_a)
    );

    data_accumulator_avg #(.DATA_WIDTH(DW), .ACC_WIDTH(AW_B), .DEPTH(DEPTH), .REC_WIDTH(RW)) dut_b (
        .clk(clk), .rst(rst), .inputData(inputData), .dataCaptureStrobe(dataCaptureStrobe),
        .start(start), .abort(abort), .numRecords(numRecords), .dataRead(dataRead),
        .dataReadyToRead(rdy_b), .dataEmpty(emp_b), .dataOut(out_b), .busy(busy_b),
        .recordCount(rc_b), .overflow(ovf_b)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [31:0] oa, input logic [31:0] ob, input logic [31:0] exp);
        check({tag, "_acc16"}, oa, exp);
        check({tag, "_acc10"}, ob, exp);
    endtask

    function automatic int clamp(input int v, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // kind: 0 = constant val, 1 = ramp val, val-1, ..., 2 = random full-range samples
    task automatic capture(input int kind, input int val, input bit mid_strobe);
        int s, sum;
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                0:       s = val;
                1:       s = val - i;
                default: s = int'($urandom_range(0, 255)) - 128;
            endcase
            inputData         = DW'(s);
            dataCaptureStrobe = (i == 0) || (mid_strobe && i == DEPTH / 2);
            tick();
            start = 1'b0;
            if (recs_done == 0) begin
                m_a[i] = s;
                m_b[i] = s;
            end else begin
                sum    = m_a[i] + s;
                m_a[i] = clamp(sum, AW_A);
                if (m_a[i] != sum) mo_a = 1'b1;
                sum    = m_b[i] + s;
                m_b[i] = clamp(sum, AW_B);
                if (m_b[i] != sum) mo_b = 1'b1;
            end
        end
        dataCaptureStrobe = 1'b0;
        recs_done++;
    endtask

    task automatic readout(input bit hold);
        for (int w = 0; w < DEPTH; w++) begin
            int lat = 0;
            if (hold) dataRead = 1'b1;
            else begin
                dataRead = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            while (rdy_a !== 1'b1 && lat < 8) begin
                tick();
                lat++;
            end
            check_ctl($sformatf("w%0d_ready", w), rdy_a, rdy_b, 1);
            if (hold) check($sformatf("w%0d_hold_gap", w), lat, 0);
            check_ctl($sformatf("w%0d_empty", w), emp_a, emp_b, 0);
            check($sformatf("w%0d_data_acc16", w), out_a, m_a[w]);
            check($sformatf("w%0d_data_acc10", w), out_b, m_b[w]);
            dataRead = 1'b1;
            tick();
            check_ctl($sformatf("w%0d_ready_drop", w), rdy_a, rdy_b, 0);
            if (!hold) dataRead = 1'($urandom_range(0, 1));
            if (w < DEPTH - 1) tick();
        end
        check_ctl("end_empty", emp_a, emp_b, 1);
        check_ctl("end_busy", busy_a, busy_b, 0);
        check("end_data_acc16", out_a, m_a[DEPTH-1]);
        check("end_data_acc10", out_b, m_b[DEPTH-1]);
        dataRead = 1'b1;
        repeat (3) tick();
        check_ctl("extra_read_ready", rdy_a, rdy_b, 0);
        check_ctl("extra_read_empty", emp_a, emp_b, 1);
        check_ctl("extra_read_busy", busy_a, busy_b, 0);
        check("extra_read_data_acc16", out_a, m_a[DEPTH-1]);
        check("extra_read_data_acc10", out_b, m_b[DEPTH-1]);
        dataRead = 1'b0;
    endtask

    task automatic run(input int nrec, input int kind, input int val, input bit hold, input bit poke);
        int eff = (nrec == 0) ? 1 : nrec;
        int lat = 0;
        numRecords = RW'(nrec);
        start      = 1'b1;
        tick();
        start     = 1'b0;
        recs_done = 0;
        mo_a      = 1'b0;
        mo_b      = 1'b0;
        check_ctl("run_busy", busy_a, busy_b, 1);
        check_ctl("run_rc_clear", rc_a, rc_b, 0);
        for (int r = 0; r < eff; r++) begin
            if (r > 0) begin
                tick();
                check_ctl($sformatf("rc_after_rec%0d", r), rc_a, rc_b, r);
                repeat ($urandom_range(0, 2)) tick();
                if (poke) begin
                    start      = 1'b1;
                    numRecords = 8'd1;
                end
            end
            capture(kind, val, poke);
        end
        while (rdy_a !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        check("drain_latency_le3", lat <= 3, 1);
        check_ctl("rc_final", rc_a, rc_b, eff);
        check("ovf_acc16", ovf_a, mo_a);
        check("ovf_acc10", ovf_b, mo_b);
        readout(hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b0;
        inputData         = '0;
        dataCaptureStrobe = 1'b0;
        start             = 1'b0;
        abort             = 1'b0;
        dataRead          = 1'b0;
        numRecords        = '0;
        repeat (2) @(negedge clk);
        check_ctl("rst_busy", busy_a, busy_b, 0);
        check_ctl("rst_ready", rdy_a, rdy_b, 0);
        check_ctl("rst_empty", emp_a, emp_b, 1);
        check_ctl("rst_dout", out_a, out_b, 0);
        check_ctl("rst_rc", rc_a, rc_b, 0);
        check_ctl("rst_ovf", ovf_a, ovf_b, 0);
        rst = 1'b1;
        tick();

        // Single record ramp -3..-18, random read pacing.
        run(1, 1, -3, 1'b0, 1'b0);
        // Four records of -3 with a stray mid-capture strobe and a start poked in WAIT_TRIG.
        run(4, 0, -3, 1'b1, 1'b1);
        // Saturation in the 10-bit instance, both polarities.
        run(8, 0, 127, 1'b0, 1'b0);
        run(8, 0, -128, 1'b1, 1'b0);
        // numRecords = 0 behaves as one record.
        run(0, 2, 0, 1'b0, 1'b0);

        // Abort during the second record of three.
        numRecords = 8'd3;
        start      = 1'b1;
        tick();
        start     = 1'b0;
        recs_done = 0;
        mo_a      = 1'b0;
        mo_b      = 1'b0;
        capture(0, 5, 1'b0);
        tick();
        check_ctl("abort_rc_before", rc_a, rc_b, 1);
        for (int i = 0; i < 6; i++) begin
            inputData         = 8'sd7;
            dataCaptureStrobe = (i == 0);
            tick();
        end
        dataCaptureStrobe = 1'b0;
        abort             = 1'b1;
        tick();
        abort = 1'b0;
        check_ctl("abort_busy", busy_a, busy_b, 0);
        check_ctl("abort_ready", rdy_a, rdy_b, 0);
        check_ctl("abort_empty", emp_a, emp_b, 1);
        check_ctl("abort_dout", out_a, out_b, 0);
        check_ctl("abort_rc_held", rc_a, rc_b, 1);
        check_ctl("abort_ovf_held", ovf_a, ovf_b, 0);

        // start and abort together, then strobes in IDLE: nothing starts.
        numRecords = 8'd2;
        start      = 1'b1;
        abort      = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_ctl("start_abort_busy", busy_a, busy_b, 0);
        dataCaptureStrobe = 1'b1;
        repeat (2) tick();
        dataCaptureStrobe = 1'b0;
        tick();
        check_ctl("idle_strobe_busy", busy_a, busy_b, 0);
        check_ctl("start_abort_rc_held", rc_a, rc_b, 1);

        // Asynchronous reset in the middle of a capture.
        numRecords = 8'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            inputData         = DW'($urandom_range(0, 255));
            dataCaptureStrobe = (i == 0);
            tick();
        end
        dataCaptureStrobe = 1'b0;
        rst               = 1'b0;
        #1;
        check_ctl("midrst_busy", busy_a, busy_b, 0);
        check_ctl("midrst_ready", rdy_a, rdy_b, 0);
        check_ctl("midrst_empty", emp_a, emp_b, 1);
        check_ctl("midrst_dout", out_a, out_b, 0);
        check_ctl("midrst_rc", rc_a, rc_b, 0);
        check_ctl("midrst_ovf", ovf_a, ovf_b, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Recovery run after reset: a fresh first record must overwrite everything.
        run(2, 2, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
